fifo_uart_tx: RTL and testbench

- Downstream consumer of the synchronous FIFO. Pops one word whenever the FIFO is non-empty and the serializer is idle.
- Transmits each word on a single UART line: 8N1 format, LSB first, with a fixed clock-cycles-per-bit divider.
- Gives the FIFO a back-pressure-correct read port and an observable serial output for board bring-up.

---
 rtl/fifo_uart_tx_pkg.sv | 15 +
 rtl/fifo_uart_tx_baud_tick_gen.sv | 25 ++
 rtl/fifo_uart_tx.sv | 109 ++++++++++
 tb/tb_fifo_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared state encoding and width helper for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// baud_tick_gen: bit-period divider; o_tick flags the cycle just before each bit boundary
module baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CW = width_of(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  // count 0..CLKS_PER_BIT-1, wrapping on each bit boundary and held at zero while cleared
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= (i_clear || r_cnt == LAST) ? '0 : r_cnt + 1'b1;

  // one cycle of look-ahead lets the sequencer register its bit-end and frame-done flags
  assign o_tick = !i_clear && r_cnt == PRE;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and sends each as an 8N1 UART frame, LSB first
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_frame_done
);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_idx;
  logic                  r_bit_end;
  logic                  r_tx;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_tick;
  logic                  w_clear;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_clear      = r_state inside {S_IDLE, S_POP, S_LOAD};
  assign w_shift_next = r_shift >> 1;
  assign o_tx         = r_tx;
  assign o_fifo_rd_en = r_rd_en;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  // delay the look-ahead tick so r_bit_end is high in the last cycle of every bit
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_bit_end <= 1'b0;
    else          r_bit_end <= w_tick;

  // frame sequencer: pop, load, then shift start/data/stop bits out with registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= r_state == S_STOP && w_tick;
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= !i_fifo_empty;
          if (!i_fifo_empty) begin
            r_state <= S_POP;
            r_rd_en <= 1'b1;
          end
        end
        S_POP: r_state <= S_LOAD;
        S_LOAD: begin
          r_shift <= i_fifo_data;
          r_idx   <= '0;
          r_tx    <= 1'b0;
          r_state <= S_START;
        end
        S_START:
          if (r_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        S_DATA:
          if (r_bit_end) begin
            if (r_idx == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift <= w_shift_next;
              r_tx    <= w_shift_next[0];
              r_idx   <= r_idx + 1'b1;
            end
          end
        S_STOP:
          if (r_bit_end) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; stimulus queues expected bytes, a UART decoder checks each frame
module tb_fifo_uart_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          rd_en, tx, busy, done;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  int n_rd = 0, n_done = 0, cyc = 0, last_end = 0, n_gap = 0;
  bit chk_gap = 0, have_prev = 0;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_rd_en (rd_en),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_frame_done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic wait_idle(input string name, input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_q.size() == 0 && busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  // FIFO model: data appears after the cycle in which rd_en is high
  always @(negedge clk) begin
    if (rd_en) begin
      n_rd++;
      chk("pop_nonempty", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    end
    if (done) n_done++;
    fifo_empty = fifo_q.size() == 0;
  end

  // UART decoder and scoreboard
  initial begin : monitor
    logic [9:0] bits;
    bit shape_ok, aborted;
    int start_cyc;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && tx === 1'b0) begin
        start_cyc = cyc;
        if (chk_gap && have_prev) begin
          chk("interframe_gap", start_cyc - last_end - 1, 3);
          n_gap++;
        end
        shape_ok = 1;
        aborted  = 0;
        bits     = '0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) begin
            @(negedge clk);
            cyc++;
          end
          if (!rst_n) begin
            aborted = 1;
            break;
          end
          if (k % CPB == 0) bits[k/CPB] = tx;
          else if (tx !== bits[k/CPB]) shape_ok = 0;
          if (done !== (k == 10 * CPB - 1)) shape_ok = 0;
          if (busy !== 1'b1) shape_ok = 0;
        end
        if (aborted) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          have_prev = 0;
        end else begin
          chk("frame_shape", shape_ok, 1);
          chk("frame_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("frame_data", {bits[9], bits[8:1]}, {1'b1, exp_q.pop_front()});
          last_end  = cyc;
          have_prev = chk_gap;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rd0, done0;
    bit found, quiet;
    // 1: reset hold with a word waiting
    #1 push(8'h3C);
    repeat (3) begin
      @(negedge clk);
      chk("reset_tx", tx, 1);
      chk("reset_rd_en", rd_en, 0);
      chk("reset_busy", busy, 0);
    end
    chk("reset_no_pop", n_rd, 0);
    rst_n = 1'b1;
    wait_idle("t1_idle", 200);
    // 2: single word with latency check
    @(posedge clk); #1;
    rd0 = n_rd; done0 = n_done;
    push(8'hA5);
    @(posedge clk); #1;
    chk("t2_pop_rd_en", rd_en, 1);
    chk("t2_pop_busy", busy, 1);
    chk("t2_pop_tx", tx, 1);
    @(posedge clk); #1;
    chk("t2_load_rd_en", rd_en, 0);
    chk("t2_load_tx", tx, 1);
    @(posedge clk); #1;
    chk("t2_start_tx", tx, 0);
    wait_idle("t2_idle", 200);
    chk("t2_rd_count", n_rd - rd0, 1);
    chk("t2_done_count", n_done - done0, 1);
    chk("t2_empty", fifo_empty, 1);
    // 3: burst of four back-to-back frames
    @(posedge clk); #1;
    rd0 = n_rd; n_gap = 0; chk_gap = 1;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    wait_idle("t3_idle", 600);
    chk_gap = 0;
    chk("t3_gap_checks", n_gap, 3);
    chk("t3_rd_count", n_rd - rd0, 4);
    chk("t3_empty", fifo_empty, 1);
    // 4: empty FIFO stays quiet
    rd0 = n_rd; quiet = 1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) quiet = 0;
    end
    chk("t4_quiet_line", quiet, 1);
    chk("t4_rd_count", n_rd - rd0, 0);
    // 5: reset during data bit 3, next word sent cleanly
    @(posedge clk); #1;
    rd0 = n_rd;
    push(8'hFF);
    push(8'h5A);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1;
        break;
      end
    end
    chk("t5_start_seen", found, 1);
    repeat (17) @(posedge clk);
    #2;
    chk("t5_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_tx", tx, 1);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_rd_en", rd_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("t5_idle", 300);
    chk("t5_rd_count", n_rd - rd0, 2);
    // 6: FIFO empties right after the pop; frame still completes
    @(posedge clk); #1;
    rd0 = n_rd;
    push(8'h77);
    repeat (3) @(negedge clk);
    chk("t6_empty_after_pop", fifo_empty, 1);
    chk("t6_busy_in_flight", busy, 1);
    wait_idle("t6_idle", 200);
    repeat (20) @(negedge clk);
    chk("t6_rd_count", n_rd - rd0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
